// File: rtl/pkt_source.sv
// pkt_source: NetFPGA-format packet generator for the user data path.
// Each packet is a module header, three header words and N payload words.
// A 7-byte pattern can be planted in one chosen payload word so that the
// downstream match/drop stages see known stimulus.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | after reset, waiting for start
//   MODHDR  | emit module header (ctrl FF, lengths, port mask)
//   HDR     | emit header words 0..2 (word 0 carries seq)
//   PAYLOAD | emit payload words 0..N-1, last one flagged as EOP
//   GAP     | inter-packet idle, IPG_CYCLES long
//   DONE    | run finished, done held until next start or reset
//
// Only DATA_WIDTH = 64 is supported; word assembly is fixed at 64 bits.
module pkt_source #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int IPG_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [15:0]           pkt_count_i,
  input  logic [7:0]            payload_words_i,
  input  logic [2:0]            last_bytes_i,
  input  logic [7:0]            pat_index_i,
  input  logic [55:0]           pattern_i,
  input  logic [15:0]           out_port_mask_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CTRL_WIDTH-1:0] out_ctrl_o,
  output logic                  out_wr_o,
  input  logic                  out_rdy_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           pkts_sent_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MODHDR  = 3'd1,
    S_HDR     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // GAP is a down-counter; entering with IPG_CYCLES-1 yields IPG_CYCLES cycles.
  localparam int          GAP_LOAD_I = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
  localparam logic [15:0] GAP_LOAD   = GAP_LOAD_I[15:0];

  state_t          state_q, state_d;
  logic [15:0]     left_q, left_d;       // packets still to send in this run
  logic [7:0]      n_q, n_d;             // payload words, already mapped 0 -> 1
  logic [3:0]      b_q, b_d;             // valid EOP bytes, already mapped 0 -> 8
  logic [7:0]      pidx_q, pidx_d;
  logic [55:0]     pat_q, pat_d;
  logic [15:0]     mask_q, mask_d;
  logic [31:0]     seq_q, seq_d;
  logic [31:0]     sent_q, sent_d;
  logic [7:0]      widx_q, widx_d;       // word index within HDR or PAYLOAD
  logic [15:0]     gap_q, gap_d;
  logic            stop_q, stop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic            wr_q, wr_d;

  logic [15:0] word_len;
  logic [15:0] byte_len;
  logic [7:0]  eop_ctrl;
  logic        last_word;
  logic        stop_any;

  // Length fields and EOP marker derived from the latched configuration.
  always_comb begin
    word_len  = 16'd3 + {8'd0, n_q};
    byte_len  = 16'd16 + {5'd0, n_q, 3'd0} + {12'd0, b_q};
    eop_ctrl  = 8'h01 << (4'd8 - b_q);
    last_word = (widx_q == (n_q - 8'd1));
    stop_any  = stop_q | stop_i;
  end

  // Next-state, word assembly and counter updates.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    n_d     = n_q;
    b_d     = b_q;
    pidx_d  = pidx_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    seq_d   = seq_q;
    sent_d  = sent_q;
    widx_d  = widx_q;
    gap_d   = gap_q;
    stop_d  = stop_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    wr_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // stop is meaningless here; start takes priority when both arrive.
        if (start_i) begin
          n_d     = (payload_words_i == 8'd0) ? 8'd1 : payload_words_i;
          b_d     = (last_bytes_i == 3'd0) ? 4'd8 : {1'b0, last_bytes_i};
          pidx_d  = pat_index_i;
          pat_d   = pattern_i;
          mask_d  = out_port_mask_i;
          left_d  = pkt_count_i;
          seq_d   = 32'd0;
          sent_d  = 32'd0;
          widx_d  = 8'd0;
          stop_d  = 1'b0;
          state_d = (pkt_count_i == 16'd0) ? S_DONE : S_MODHDR;
        end
      end

      S_MODHDR: begin
        if (stop_i) stop_d = 1'b1;
        if (out_rdy_i) begin
          wr_d    = 1'b1;
          ctrl_d  = 8'hFF;
          data_d  = {mask_q, word_len, 16'h0000, byte_len};
          widx_d  = 8'd0;
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        if (stop_i) stop_d = 1'b1;
        if (out_rdy_i) begin
          wr_d   = 1'b1;
          ctrl_d = 8'h00;
          data_d = (widx_q == 8'd0) ? {32'h0, seq_q} : 64'h0;
          if (widx_q == 8'd2) begin
            widx_d  = 8'd0;
            state_d = S_PAYLOAD;
          end else begin
            widx_d = widx_q + 8'd1;
          end
        end
      end

      S_PAYLOAD: begin
        if (stop_i) stop_d = 1'b1;
        if (out_rdy_i) begin
          wr_d   = 1'b1;
          data_d = (widx_q == pidx_q) ? {pat_q, 8'h00}
                                      : {seq_q, 24'h0, widx_q};
          ctrl_d = last_word ? eop_ctrl : 8'h00;
          if (last_word) begin
            seq_d  = seq_q + 32'd1;
            sent_d = sent_q + 32'd1;
            left_d = left_q - 16'd1;
            widx_d = 8'd0;
            if ((left_q == 16'd1) || stop_any) begin
              stop_d  = 1'b0;
              state_d = S_DONE;
            end else if (IPG_CYCLES == 0) begin
              state_d = S_MODHDR;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end
          end else begin
            widx_d = widx_q + 8'd1;
          end
        end
      end

      S_GAP: begin
        if (stop_any) begin
          stop_d  = 1'b0;
          state_d = S_DONE;
        end else if (gap_q == 16'd0) begin
          state_d = S_MODHDR;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      left_q  <= 16'd0;
      n_q     <= 8'd1;
      b_q     <= 4'd8;
      pidx_q  <= 8'd0;
      pat_q   <= 56'd0;
      mask_q  <= 16'd0;
      seq_q   <= 32'd0;
      sent_q  <= 32'd0;
      widx_q  <= 8'd0;
      gap_q   <= 16'd0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      n_q     <= n_d;
      b_q     <= b_d;
      pidx_q  <= pidx_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      seq_q   <= seq_d;
      sent_q  <= sent_d;
      widx_q  <= widx_d;
      gap_q   <= gap_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      wr_q    <= wr_d;
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    busy_o = (state_q == S_MODHDR) || (state_q == S_HDR) ||
             (state_q == S_PAYLOAD) || (state_q == S_GAP);
    done_o = (state_q == S_DONE);
  end

  assign out_data_o  = data_q;
  assign out_ctrl_o  = ctrl_q;
  assign out_wr_o    = wr_q;
  assign pkts_sent_o = sent_q;

endmodule

// File: tb/tb_pkt_source.sv
// tb_pkt_source: directed and randomized runs of pkt_source, every written
// word compared against a packet-level model of the output stream.
module tb_pkt_source;

  localparam int IPG = 4;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, stop_i, out_rdy_i;
  logic [15:0] pkt_count_i, out_port_mask_i;
  logic [7:0]  payload_words_i, pat_index_i;
  logic [2:0]  last_bytes_i;
  logic [55:0] pattern_i;
  logic [63:0] out_data_o;
  logic [7:0]  out_ctrl_o;
  logic        out_wr_o, busy_o, done_o;
  logic [31:0] pkts_sent_o;

  pkt_source #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .IPG_CYCLES(IPG)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .pkt_count_i(pkt_count_i), .payload_words_i(payload_words_i),
    .last_bytes_i(last_bytes_i), .pat_index_i(pat_index_i),
    .pattern_i(pattern_i), .out_port_mask_i(out_port_mask_i),
    .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o), .out_wr_o(out_wr_o),
    .out_rdy_i(out_rdy_i), .busy_o(busy_o), .done_o(done_o),
    .pkts_sent_o(pkts_sent_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        rdy_last = 1'b0;
  logic [71:0] cap_q[$];
  int          cap_cyc[$];
  logic [71:0] exp_q[$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, log any write and check it was allowed.
  task automatic cycle();
    @(negedge clk_i);
    cyc++;
    if (out_wr_o === 1'b1) begin
      cap_q.push_back({out_data_o, out_ctrl_o});
      cap_cyc.push_back(cyc);
      chk("wr_after_rdy", rdy_last, 1'b1);
    end
  endtask

  task automatic drive_rdy(input int pct);
    out_rdy_i = ($urandom_range(0, 99) < pct);
    rdy_last  = out_rdy_i;
  endtask

  // Expected stream: whole packets built from the packet format rules.
  task automatic build_expected(input logic [7:0] nw, input logic [2:0] lb,
                                input logic [7:0] pi, input logic [55:0] pat,
                                input logic [15:0] mask, input int npk);
    int n, b;
    logic [15:0] wl, bl;
    logic [63:0] d;
    logic [7:0]  c;
    n = (nw == 0) ? 1 : int'(nw);
    b = (lb == 0) ? 8 : int'(lb);
    wl = 16'(3 + n);
    bl = 16'(24 + 8 * (n - 1) + b);
    exp_q.delete();
    for (int p = 0; p < npk; p++) begin
      exp_q.push_back({mask, wl, 16'h0, bl, 8'hFF});
      exp_q.push_back({32'h0, 32'(p), 8'h00});
      exp_q.push_back(72'h0);
      exp_q.push_back(72'h0);
      for (int i = 0; i < n; i++) begin
        d = (i == int'(pi)) ? {pat, 8'h00} : {32'(p), 24'h0, 8'(i)};
        c = (i == n - 1) ? 8'(1 << (8 - b)) : 8'h00;
        exp_q.push_back({d, c});
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    int mm = 0;
    int lim;
    chk({tag, "_len"}, 72'(cap_q.size()), 72'(exp_q.size()));
    lim = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      if (cap_q[i] !== exp_q[i]) begin
        if (mm == 0) chk({tag, "_first_bad_word"}, cap_q[i], exp_q[i]);
        mm++;
      end
    end
    chk({tag, "_mismatches"}, 72'(mm), 72'd0);
  endtask

  // One complete run: start, optional stop pulse after a given write count,
  // config scrambled after start, then stream, status and timing checks.
  task automatic run(input string tag, input logic [15:0] cnt, input logic [7:0] nw,
                     input logic [2:0] lb, input logic [7:0] pi, input logic [55:0] pat,
                     input logic [15:0] mask, input int pct, input int stop_after,
                     input bit stop_with_start, input int exp_pkts);
    bit seen_done = 0;
    bit stopped = 0;
    int wpp;
    pkt_count_i = cnt; payload_words_i = nw; last_bytes_i = lb;
    pat_index_i = pi; pattern_i = pat; out_port_mask_i = mask;
    start_i = 1'b1; stop_i = stop_with_start;
    drive_rdy(pct);
    cap_q.delete(); cap_cyc.delete();
    cycle();
    start_i = 1'b0; stop_i = 1'b0;
    pkt_count_i = 16'($urandom); payload_words_i = 8'($urandom);
    last_bytes_i = 3'($urandom); pat_index_i = 8'($urandom);
    pattern_i = {24'($urandom), 32'($urandom)}; out_port_mask_i = 16'($urandom);
    if (done_o === 1'b1) seen_done = 1;
    for (int k = 0; k < 6000 && !seen_done; k++) begin
      drive_rdy(pct);
      stop_i = 1'b0;
      if (stop_after >= 0 && !stopped && cap_q.size() == stop_after) begin
        stop_i = 1'b1;
        stopped = 1;
      end
      cycle();
      if (done_o === 1'b1) seen_done = 1;
    end
    stop_i = 1'b0;
    chk({tag, "_done_reached"}, seen_done, 1'b1);
    chk({tag, "_busy_in_done"}, busy_o, 1'b0);
    chk({tag, "_pkts_sent"}, pkts_sent_o, 72'(exp_pkts));
    build_expected(nw, lb, pi, pat, mask, exp_pkts);
    compare_stream(tag);
    wpp = 4 + ((nw == 0) ? 1 : int'(nw));
    if (pct == 100 && exp_pkts > 0 && cap_cyc.size() > 0)
      chk({tag, "_span"}, 72'(cap_cyc[cap_cyc.size() - 1] - cap_cyc[0] + 1),
          72'(exp_pkts * wpp + (exp_pkts - 1) * IPG));
  endtask

  initial begin
    logic [55:0] pat;
    int wpp;
    bit hit;
    reset_i = 1'b1; start_i = 0; stop_i = 0; out_rdy_i = 0;
    pkt_count_i = 0; payload_words_i = 0; last_bytes_i = 0; pat_index_i = 0;
    pattern_i = 0; out_port_mask_i = 0;
    repeat (3) cycle();
    chk("rst_out_wr", out_wr_o, 1'b0);
    chk("rst_out_data", out_data_o, 72'h0);
    chk("rst_out_ctrl", out_ctrl_o, 72'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_pkts_sent", pkts_sent_o, 72'h0);
    reset_i = 1'b0;
    cycle();

    // T1: single 2-word packet, pattern in the EOP word
    pat = 56'h11_2233_4455_6677;
    run("t1", 16'd1, 8'd2, 3'd0, 8'd1, pat, 16'h0004, 100, -1, 0, 1);
    chk("t1_nwrites", 72'(cap_q.size()), 72'd6);
    chk("t1_ctrl0", cap_q[0][7:0], 8'hFF);
    chk("t1_ctrl4", cap_q[4][7:0], 8'h00);
    chk("t1_ctrl5", cap_q[5][7:0], 8'h01);
    chk("t1_byte_len", cap_q[0][23:8], 16'd40);
    chk("t1_word_len", cap_q[0][55:40], 16'd5);
    chk("t1_mask", cap_q[0][71:56], 16'h0004);
    chk("t1_word5", cap_q[5][71:8], {pat, 8'h00});
    chk("t1_done_holds", done_o, 1'b1);

    // T2: single payload word, 3 valid bytes, pattern at word 0
    pat = 56'hA1_B2C3_D4E5_F607;
    run("t2", 16'd1, 8'd1, 3'd3, 8'd0, pat, 16'h0001, 100, -1, 0, 1);
    chk("t2_eop_ctrl", cap_q[4][7:0], 8'h20);
    chk("t2_byte_len", cap_q[0][23:8], 16'd27);
    chk("t2_payload", cap_q[4][71:8], {pat, 8'h00});

    // T3: three packets, inter-packet idle gap
    run("t3", 16'd3, 8'd2, 3'd5, 8'd9, pat, 16'h0010, 100, -1, 0, 3);
    for (int k = 1; k < 3; k++)
      chk("t3_idle_gap", 72'(cap_cyc[6 * k] - cap_cyc[6 * k - 1] - 1), 72'(IPG));
    chk("t3_done", done_o, 1'b1);

    // T4: same run under random backpressure
    run("t4", 16'd3, 8'd2, 3'd5, 8'd9, pat, 16'h0010, 50, -1, 0, 3);

    // T5: stop during the second packet; stop while in gap
    run("t5", 16'd10, 8'd3, 3'd7, 8'd2, pat, 16'h0100, 100, 9, 0, 2);
    run("t5_gap", 16'd10, 8'd3, 3'd7, 8'd2, pat, 16'h0100, 100, 7, 0, 1);

    // start and stop together from DONE: stop ignored
    run("ss", 16'd2, 8'd1, 3'd1, 8'd0, pat, 16'h8000, 100, -1, 1, 2);
    chk("ss_eop_ctrl", cap_q[4][7:0], 8'h80);

    // zero packets, zero payload words
    run("zero_cnt", 16'd0, 8'd4, 3'd0, 8'd0, pat, 16'h0002, 100, -1, 0, 0);
    run("zero_nw", 16'd2, 8'd0, 3'd2, 8'd0, pat, 16'h0002, 70, -1, 0, 2);

    // randomized configurations with backpressure
    for (int r = 0; r < 5; r++) begin
      logic [15:0] c;
      c = 16'($urandom_range(1, 3));
      run("rand", c, 8'($urandom_range(0, 6)), 3'($urandom), 8'($urandom_range(0, 7)),
          {24'($urandom), 32'($urandom)}, 16'($urandom), 60, -1, 0, int'(c));
    end

    // T6: reset mid-payload, then a clean run restarts at seq 0
    pkt_count_i = 16'd5; payload_words_i = 8'd8; last_bytes_i = 3'd0;
    pat_index_i = 8'd3; pattern_i = pat; out_port_mask_i = 16'h0001;
    start_i = 1'b1; drive_rdy(100);
    cap_q.delete(); cap_cyc.delete();
    cycle();
    start_i = 1'b0;
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      cycle();
      if (cap_q.size() == 6) hit = 1;
    end
    chk("t6_reached_payload", hit, 1'b1);
    reset_i = 1'b1;
    cycle();
    chk("t6_out_wr", out_wr_o, 1'b0);
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_pkts_sent", pkts_sent_o, 72'h0);
    chk("t6_out_data", out_data_o, 72'h0);
    chk("t6_done", done_o, 1'b0);
    reset_i = 1'b0;
    cycle();
    run("t6_restart", 16'd1, 8'd2, 3'd4, 8'd0, pat, 16'h0001, 100, -1, 0, 1);
    wpp = 6;
    chk("t6_seq0", cap_q[1][39:8], 32'h0);
    chk("t6_restart_len", 72'(cap_q.size()), 72'(wpp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
